// File: rtl/fp_to_int_pipe.sv
// fp_to_int_pipe: two-stage pipelined float -> integer converter (fcvt.w[u].s class).
// Ports:
//   clk_i, rst_i              clock (rising edge), asynchronous active-high reset
//   in_valid_i / in_ready_o   input handshake
//   fp_i                      {sign, exponent, mantissa}
//   unsigned_i                1: unsigned target, 0: signed target
//   rm_i                      rounding mode: RNE, RTZ, RDN, RUP, RMM; undefined codes act as RTZ
//   tag_i / tag_o             sideband tag carried with each op
//   out_valid_o / out_ready_i output handshake
//   int_o, nv_o, nx_o         result, invalid flag, inexact flag
module fp_to_int_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   fp_i,
  input  logic                   unsigned_i,
  input  logic [2:0]             rm_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INT_W-1:0]       int_o,
  output logic                   nv_o,
  output logic                   nx_o,
  output logic [TAG_W-1:0]       tag_o
);

  localparam int WW = INT_W + MAN_W + 1;   // INT_W integer bits + MAN_W+1 fraction bits
  localparam int SW = $clog2(INT_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] INT_LIM = EW'(INT_W);
  localparam logic signed [EW-1:0] NEG1    = '1;

  // Stage registers
  logic               s1_valid_q, s1_valid_d;
  logic               s1_special_q, s1_special_d;   // NaN, inf or exponent too large
  logic               s1_sat_pos_q, s1_sat_pos_d;   // saturation direction for specials
  logic               s1_sign_q, s1_sign_d;
  logic               s1_uns_q, s1_uns_d;
  logic [2:0]         s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [INT_W-1:0]   s1_int_q, s1_int_d;
  logic               s1_guard_q, s1_guard_d;
  logic               s1_sticky_q, s1_sticky_d;

  logic               s2_valid_q, s2_valid_d;
  logic [INT_W-1:0]   s2_int_q, s2_int_d;
  logic               s2_nv_q, s2_nv_d;
  logic               s2_nx_q, s2_nx_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic s1_adv, s2_adv;

  // Stage 1 decode signals
  logic                   f_sign;
  logic [EXP_W-1:0]       f_exp;
  logic [MAN_W-1:0]       f_man;
  logic signed [EW-1:0]   unb_exp;
  logic [SW-1:0]          sh;
  logic [WW-1:0]          aligned;
  logic                   d_special, d_sat_pos, d_guard, d_sticky;
  logic [INT_W-1:0]       d_int;

  // Stage 2 rounding signals
  logic                   inc, in_range, sat_pos;
  logic [INT_W:0]         mag;
  logic [INT_W-1:0]       sat_val, r_int;
  logic                   r_nv, r_nx;

  assign s2_adv     = !s2_valid_q | out_ready_i;
  assign s1_adv     = !s1_valid_q | s2_adv;
  assign in_ready_o = s1_adv;

  // Decode and align: the hidden bit lands at weight 2^unb_exp, binary point at bit MAN_W+1,
  // so bit MAN_W is the guard and everything below folds into sticky.
  always_comb begin
    f_sign    = fp_i[EXP_W+MAN_W];
    f_exp     = fp_i[EXP_W+MAN_W-1:MAN_W];
    f_man     = fp_i[MAN_W-1:0];
    unb_exp   = $signed({2'b00, f_exp}) - BIAS;
    sh        = SW'(unb_exp + 1);
    aligned   = WW'({1'b1, f_man}) << sh;
    d_special = 1'b0;
    d_sat_pos = !f_sign;
    d_int     = '0;
    d_guard   = 1'b0;
    d_sticky  = 1'b0;
    if (f_exp == '1) begin
      d_special = 1'b1;
      d_sat_pos = (f_man != '0) | !f_sign;
    end else if (f_exp == '0) begin
      d_sticky = (f_man != '0);          // subnormal: far below one half
    end else if (unb_exp >= INT_LIM) begin
      d_special = 1'b1;                  // >= 2^INT_W: out of range for every target
    end else if (unb_exp >= NEG1) begin
      d_int    = aligned[WW-1:MAN_W+1];
      d_guard  = aligned[MAN_W];
      d_sticky = |aligned[MAN_W-1:0];
    end else begin
      d_sticky = 1'b1;
    end
  end

  // Round, range check and saturate
  always_comb begin
    case (s1_rm_q)
      3'b000:  inc = s1_guard_q & (s1_sticky_q | s1_int_q[0]);
      3'b010:  inc = s1_sign_q & (s1_guard_q | s1_sticky_q);
      3'b011:  inc = !s1_sign_q & (s1_guard_q | s1_sticky_q);
      3'b100:  inc = s1_guard_q;
      default: inc = 1'b0;
    endcase
    mag = {1'b0, s1_int_q} + (INT_W+1)'(inc);
    if (s1_uns_q)
      in_range = s1_sign_q ? (mag == '0) : !mag[INT_W];
    else if (s1_sign_q)
      in_range = !mag[INT_W] && (!mag[INT_W-1] || (mag[INT_W-2:0] == '0));
    else
      in_range = (mag[INT_W:INT_W-1] == 2'b00);
    sat_pos = s1_special_q ? s1_sat_pos_q : !s1_sign_q;
    if (s1_uns_q)
      sat_val = sat_pos ? '1 : '0;
    else
      sat_val = sat_pos ? {1'b0, {(INT_W-1){1'b1}}} : {1'b1, {(INT_W-1){1'b0}}};
    if (s1_special_q || !in_range) begin
      r_int = sat_val;
      r_nv  = 1'b1;
      r_nx  = 1'b0;
    end else begin
      r_int = s1_sign_q ? (INT_W'(0) - mag[INT_W-1:0]) : mag[INT_W-1:0];
      r_nv  = 1'b0;
      r_nx  = s1_guard_q | s1_sticky_q;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_special_d = s1_special_q;
    s1_sat_pos_d = s1_sat_pos_q;
    s1_sign_d    = s1_sign_q;
    s1_uns_d     = s1_uns_q;
    s1_rm_d      = s1_rm_q;
    s1_tag_d     = s1_tag_q;
    s1_int_d     = s1_int_q;
    s1_guard_d   = s1_guard_q;
    s1_sticky_d  = s1_sticky_q;
    s2_valid_d   = s2_valid_q;
    s2_int_d     = s2_int_q;
    s2_nv_d      = s2_nv_q;
    s2_nx_d      = s2_nx_q;
    s2_tag_d     = s2_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_special_d = d_special;
        s1_sat_pos_d = d_sat_pos;
        s1_sign_d    = f_sign;
        s1_uns_d     = unsigned_i;
        s1_rm_d      = rm_i;
        s1_tag_d     = tag_i;
        s1_int_d     = d_int;
        s1_guard_d   = d_guard;
        s1_sticky_d  = d_sticky;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_int_d = r_int;
        s2_nv_d  = r_nv;
        s2_nx_d  = r_nx;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_special_q <= 1'b0;
      s1_sat_pos_q <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_uns_q     <= 1'b0;
      s1_rm_q      <= '0;
      s1_tag_q     <= '0;
      s1_int_q     <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_int_q     <= '0;
      s2_nv_q      <= 1'b0;
      s2_nx_q      <= 1'b0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_special_q <= s1_special_d;
      s1_sat_pos_q <= s1_sat_pos_d;
      s1_sign_q    <= s1_sign_d;
      s1_uns_q     <= s1_uns_d;
      s1_rm_q      <= s1_rm_d;
      s1_tag_q     <= s1_tag_d;
      s1_int_q     <= s1_int_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s2_valid_q   <= s2_valid_d;
      s2_int_q     <= s2_int_d;
      s2_nv_q      <= s2_nv_d;
      s2_nx_q      <= s2_nx_d;
      s2_tag_q     <= s2_tag_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign int_o       = s2_int_q;
  assign nv_o        = s2_nv_q;
  assign nx_o        = s2_nx_q;
  assign tag_o       = s2_tag_q;

endmodule
